// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction decode stage with register-file read, writeback bypass,
//   load-use hazard detection and the ID/EX pipeline register.
//
//   Instruction layout (default REG_NUMBER=5):
//     opcode[19:15] rd[14:10] rs1[9:5] rs2/imm5[4:0]
//
//   Ports
//     clk, rst                 : clock, synchronous active-high reset
//     instr_in, instr_valid    : instruction from IF/ID and its valid flag
//     flush                    : kills the instruction currently in ID
//     rs1, rs2                 : register-file read addresses (combinational)
//     data_rs1, data_rs2       : register-file read data (combinational)
//     wb_reg_write/wb_rd/wb_data : writeback port, bypassed into operands
//     stall                    : load-use hazard, upstream must hold
//     ex_*                     : registered ID/EX fields, operands, controls
//     stall_count              : saturating count of load-use bubbles
//
//   Handshake: an instruction is consumed at a rising edge when
//   instr_valid=1 and stall=0 (a flush also consumes it, as a bubble).
//   While stall=1 upstream keeps instr_in/instr_valid unchanged and the
//   same instruction is re-evaluated on the next cycle.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_WIDTH = 20,
    parameter int REG_NUMBER = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*REG_NUMBER-1:0] instr_in,
    input  logic                    instr_valid,
    input  logic                    flush,
    output logic [REG_NUMBER-1:0]   rs1,
    output logic [REG_NUMBER-1:0]   rs2,
    input  logic [DATA_WIDTH-1:0]   data_rs1,
    input  logic [DATA_WIDTH-1:0]   data_rs2,
    input  logic                    wb_reg_write,
    input  logic [REG_NUMBER-1:0]   wb_rd,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [4:0]              ex_opcode,
    output logic [REG_NUMBER-1:0]   ex_rd,
    output logic [REG_NUMBER-1:0]   ex_rs1,
    output logic [REG_NUMBER-1:0]   ex_rs2,
    output logic [DATA_WIDTH-1:0]   ex_op_a,
    output logic [DATA_WIDTH-1:0]   ex_op_b,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_branch,
    output logic                    ex_illegal,
    output logic [15:0]             stall_count
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00011;
    localparam logic [4:0] OP_LOAD  = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b00101;
    localparam logic [4:0] OP_BEQ   = 5'b00110;

    // Field extraction
    logic [4:0]            opcode;
    logic [REG_NUMBER-1:0] rd;
    logic [4:0]            imm5;

    assign opcode = instr_in[4*REG_NUMBER-1 -: 5];
    assign rd     = instr_in[3*REG_NUMBER-1 : 2*REG_NUMBER];
    assign rs1    = instr_in[2*REG_NUMBER-1 : REG_NUMBER];
    assign rs2    = instr_in[REG_NUMBER-1 : 0];
    assign imm5   = instr_in[4:0];

    // Opcode decode
    logic dec_reg_write;
    logic dec_mem_read;
    logic dec_mem_write;
    logic dec_branch;
    logic dec_illegal;
    logic use_rs1;
    logic use_rs2;
    logic use_imm;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_illegal   = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_imm       = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin
                dec_reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_imm       = 1'b1;
            end
            OP_LOAD: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                use_rs1       = 1'b1;
                use_imm       = 1'b1;
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BEQ: begin
                dec_branch    = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Operands: writeback data wins over the register file so a value being
    // written this cycle is seen by the instruction reading it this cycle.
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] op_b;

    assign src_a   = (wb_reg_write && wb_rd == rs1) ? wb_data : data_rs1;
    assign src_b   = (wb_reg_write && wb_rd == rs2) ? wb_data : data_rs2;
    assign imm_ext = {{(DATA_WIDTH-5){imm5[4]}}, imm5};
    assign op_b    = use_imm ? imm_ext : src_b;

    // Load-use hazard: the load in ID/EX has no data until after EX/MEM, so a
    // consumer in ID must wait one cycle. Reset and flush suppress it.
    logic rd_hit;
    assign rd_hit = (use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2);
    assign stall  = !rst && !flush && instr_valid && ex_valid && ex_mem_read && rd_hit;

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            stall_count  <= '0;
        end else if (flush || stall) begin
            // Bubble. stall is already 0 under flush, so only real
            // load-use bubbles are counted.
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end else begin
            ex_valid     <= instr_valid;
            ex_opcode    <= opcode;
            ex_rd        <= rd;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_op_a      <= src_a;
            ex_op_b      <= op_b;
            ex_reg_write <= instr_valid && dec_reg_write;
            ex_mem_read  <= instr_valid && dec_mem_read;
            ex_mem_write <= instr_valid && dec_mem_write;
            ex_branch    <= instr_valid && dec_branch;
            ex_illegal   <= instr_valid && dec_illegal;
        end
    end

endmodule
